// File: rtl/cassette_rec_if.sv
// SDRAM tape-buffer write port: the recorder presents address/data with a held
// request, the memory side answers with a single-cycle accept.
interface cassette_rec_if;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_dout;
    logic        sdram_wr;
    logic        sdram_ack;

    modport master (output sdram_addr, output sdram_dout, output sdram_wr, input sdram_ack);
    modport slave  (input sdram_addr, input sdram_dout, input sdram_wr, output sdram_ack);
endinterface

// File: rtl/cassette_rec.sv
// Oric CSAVE decoder: measures rising-edge periods of the tape square wave,
// frames start/8 data/parity bits and appends each byte to the SDRAM tape buffer.
module cassette_rec #(
    parameter int unsigned P_MIN    = 2500,
    parameter int unsigned P_THRESH = 15000,
    parameter int unsigned P_MAX    = 40000,
    parameter logic [24:0] ADDR_MAX = 25'h1FFFFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  rewind,
    input  logic                  tape_in,
    cassette_rec_if.master        sdram,
    output logic [24:0]           tape_end,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  full,
    output logic [2:0]            status
);

    localparam logic [15:0] MIN_C = 16'(P_MIN);
    localparam logic [15:0] THR_C = 16'(P_THRESH);
    localparam logic [15:0] MAX_C = 16'(P_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HUNT   = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STORE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic        en_q, rew_q;
    logic [15:0] cnt_q, cnt_d;
    logic        have_edge_q, have_edge_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [24:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic [24:0] tape_end_q, tape_end_d;
    logic        perr_q, perr_d;
    logic        ovr_q, ovr_d;
    logic        full_q, full_d;

    logic rise, glitch, bit_evt, bit_val, tmo, ack_fire;
    logic en_rise, en_fall, rew_rise;

    // sync_q[1] is the second synchroniser stage, sync_q[2] its previous value
    assign sync_d   = {sync_q[1:0], tape_in};
    assign rise     = sync_q[1] & ~sync_q[2];
    assign glitch   = cnt_q < MIN_C;
    assign bit_val  = cnt_q < THR_C;
    assign bit_evt  = rise && have_edge_q && !glitch && (cnt_q <= MAX_C);
    assign tmo      = (rise && have_edge_q && (cnt_q > MAX_C))
                   || ((cnt_q > MAX_C) && (state_q == DATA || state_q == PARITY));
    assign ack_fire = wr_q & sdram.sdram_ack;
    assign en_rise  = en & ~en_q;
    assign en_fall  = ~en & en_q;
    assign rew_rise = rewind & ~rew_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            en_q        <= 1'b0;
            rew_q       <= 1'b0;
            cnt_q       <= '0;
            have_edge_q <= 1'b0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            tape_end_q  <= '0;
            perr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            en_q        <= en;
            rew_q       <= rewind;
            cnt_q       <= cnt_d;
            have_edge_q <= have_edge_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            tape_end_q  <= tape_end_d;
            perr_q      <= perr_d;
            ovr_q       <= ovr_d;
            full_q      <= full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        have_edge_d = have_edge_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = wr_q;
        tape_end_d  = tape_end_q;
        perr_d      = perr_q;
        ovr_d       = ovr_q;
        full_d      = full_q;

        // Glitch edges leave the period counter running so the real period survives
        if (state_q != IDLE && rise && (!have_edge_q || !glitch)) begin
            cnt_d       = 16'd1;
            have_edge_d = 1'b1;
        end

        // Write completion is resolved before STORE so a coincident byte is accepted
        if (ack_fire) begin
            wr_d       = 1'b0;
            tape_end_d = addr_q + 25'd1;
            if (addr_q == ADDR_MAX) full_d = 1'b1;
            else                    addr_d = addr_q + 25'd1;
        end

        case (state_q)
            IDLE: if (en) state_d = HUNT;
            HUNT: begin
                if (bit_evt && !bit_val) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (tmo) begin
                    state_d = HUNT;
                end else if (bit_evt) begin
                    shreg_d  = {bit_val, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tmo) begin
                    state_d = HUNT;
                end else if (bit_evt) begin
                    if (!(^{shreg_q, bit_val})) perr_d = 1'b1;
                    state_d = STORE;
                end
            end
            STORE: begin
                if (full_d)    ;
                else if (wr_d) ovr_d = 1'b1;
                else begin
                    dout_d = shreg_q;
                    wr_d   = 1'b1;
                end
                state_d = HUNT;
            end
            default: state_d = IDLE;
        endcase

        if (en_rise) begin
            perr_d      = 1'b0;
            ovr_d       = 1'b0;
            have_edge_d = 1'b0;
            state_d     = HUNT;
        end else if (en_fall) begin
            state_d = IDLE;
        end

        if (rew_rise) begin
            addr_d     = '0;
            tape_end_d = '0;
            wr_d       = 1'b0;
            full_d     = 1'b0;
            perr_d     = 1'b0;
            ovr_d      = 1'b0;
            state_d    = en ? HUNT : IDLE;
        end
    end

    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_dout = dout_q;
    assign sdram.sdram_wr   = wr_q;
    assign tape_end         = tape_end_q;
    assign parity_err       = perr_q;
    assign overrun          = ovr_q;
    assign full             = full_q;
    assign status           = state_q;

endmodule
